// File: rtl/seq_detector_prog.sv
// Programmable serial pattern detector with overlap control.
// Define SEQ_DET_COUNT_EN to build the saturating match counter.
module seq_detector_prog #(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = 4,
  parameter int CNT_W   = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               in_valid,
  input  logic               sequence_in,
  output logic               detector_out,
  output logic [CNT_W-1:0]   match_count,
  output logic               armed
);

  localparam logic [LEN_W-1:0] LP_MAX = LEN_W'(MAX_LEN);

  logic [MAX_LEN-1:0] r_pat;
  logic [LEN_W-1:0]   r_len;
  logic               r_ovl;
  logic               r_armed;
  logic [MAX_LEN-1:0] r_hist;
  logic [LEN_W-1:0]   r_fill;
  logic               r_det;

  logic [LEN_W-1:0]   w_len_clamp;
  logic [MAX_LEN-1:0] w_hist_nxt;
  logic [LEN_W-1:0]   w_fill_inc;
  logic [MAX_LEN-1:0] w_mask;
  logic               w_shift;
  logic               w_match;

  always_comb begin
    w_len_clamp = (cfg_len > LP_MAX) ? LP_MAX : cfg_len;
    w_shift     = in_valid && !cfg_load;
    w_hist_nxt  = {r_hist[MAX_LEN-2:0], sequence_in};
    w_fill_inc  = (r_fill == LP_MAX) ? r_fill : r_fill + 1'b1;
    // Shifting by MAX_LEN clears the vector, giving an all-ones mask.
    w_mask      = ~({MAX_LEN{1'b1}} << r_len);
    w_match     = r_armed && w_shift &&
                  (w_fill_inc >= r_len) &&
                  (((w_hist_nxt ^ r_pat) & w_mask) == '0);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_pat   <= '0;
      r_len   <= '0;
      r_ovl   <= 1'b0;
      r_armed <= 1'b0;
      r_hist  <= '0;
      r_fill  <= '0;
      r_det   <= 1'b0;
    end else if (cfg_load) begin
      r_pat   <= cfg_pattern;
      r_len   <= w_len_clamp;
      r_ovl   <= cfg_overlap;
      r_armed <= (w_len_clamp != '0);
      r_hist  <= '0;
      r_fill  <= '0;
      r_det   <= 1'b0;
    end else if (in_valid) begin
      r_hist  <= w_hist_nxt;
      r_fill  <= (w_match && !r_ovl) ? '0 : w_fill_inc;
      r_det   <= w_match;
    end else begin
      r_det   <= 1'b0;
    end
  end

`ifdef SEQ_DET_COUNT_EN
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (w_match && (r_cnt != '1)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign match_count = r_cnt;
`else
  assign match_count = '0;
`endif

  assign detector_out = r_det;
  assign armed        = r_armed;

endmodule

// File: tb/tb_seq_detector_prog.sv
// Directed self-checking bench for seq_detector_prog.
// Count expectations follow SEQ_DET_COUNT_EN (zero when undefined).
module tb_seq_detector_prog;

`ifdef SEQ_DET_COUNT_EN
  localparam int CNT_ON = 1;
`else
  localparam int CNT_ON = 0;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       cfg_load = 1'b0;
  logic [7:0] cfg_pattern = '0;
  logic [3:0] cfg_len = '0;
  logic       cfg_overlap = 1'b0;
  logic       in_valid = 1'b0;
  logic       sequence_in = 1'b0;
  logic       detector_out;
  logic [1:0] match_count;
  logic       armed;

  int total = 0;
  int bad = 0;

  seq_detector_prog #(
    .MAX_LEN(8),
    .LEN_W(4),
    .CNT_W(2)
  ) dut (
    .clock(clock),
    .reset(reset),
    .cfg_load(cfg_load),
    .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len),
    .cfg_overlap(cfg_overlap),
    .in_valid(in_valid),
    .sequence_in(sequence_in),
    .detector_out(detector_out),
    .match_count(match_count),
    .armed(armed)
  );

  always #5 clock = ~clock;

  task automatic drive(input logic v, input logic b, output logic d);
    @(negedge clock);
    in_valid = v;
    sequence_in = b;
    @(posedge clock);
    #1;
    d = detector_out;
  endtask

  task automatic load(input logic [7:0] p, input logic [3:0] l,
                      input logic o, input logic v, input logic b);
    @(negedge clock);
    cfg_load = 1'b1;
    cfg_pattern = p;
    cfg_len = l;
    cfg_overlap = o;
    in_valid = v;
    sequence_in = b;
    @(posedge clock);
    #1;
    cfg_load = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    in_valid = 1'b0;
    cfg_load = 1'b0;
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if (detector_out !== 1'b0) begin
      bad++;
      $display("FAIL rst_det got=%0b exp=0", detector_out);
    end
    total++;
    if (match_count !== 2'd0) begin
      bad++;
      $display("FAIL rst_cnt got=%0d exp=0", match_count);
    end
    total++;
    if (armed !== 1'b0) begin
      bad++;
      $display("FAIL rst_armed got=%0b exp=0", armed);
    end
  endtask

  task automatic test_overlap();
    logic d;
    logic [5:0] s;
    logic [5:0] e;
    s = 6'b101010;
    e = 6'b000101;
    do_reset();
    load(8'h0A, 4'd4, 1'b1, 1'b0, 1'b0);
    total++;
    if (armed !== 1'b1) begin
      bad++;
      $display("FAIL ovl_armed got=%0b exp=1", armed);
    end
    for (int i = 5; i >= 0; i--) begin
      drive(1'b1, s[i], d);
      total++;
      if (d !== e[i]) begin
        bad++;
        $display("FAIL ovl_bit%0d got=%0b exp=%0b", 6 - i, d, e[i]);
      end
    end
    drive(1'b0, 1'b0, d);
    total++;
    if (match_count !== 2'(2 * CNT_ON)) begin
      bad++;
      $display("FAIL ovl_cnt got=%0d exp=%0d", match_count, 2 * CNT_ON);
    end
  endtask

  task automatic test_nonoverlap();
    logic d;
    logic [7:0] s;
    logic [7:0] e;
    s = 8'b10101010;
    e = 8'b00010001;
    do_reset();
    load(8'h0A, 4'd4, 1'b0, 1'b0, 1'b0);
    for (int i = 7; i >= 0; i--) begin
      drive(1'b1, s[i], d);
      total++;
      if (d !== e[i]) begin
        bad++;
        $display("FAIL novl_bit%0d got=%0b exp=%0b", 8 - i, d, e[i]);
      end
      if (i == 2) begin
        total++;
        if (match_count !== 2'(CNT_ON)) begin
          bad++;
          $display("FAIL novl_cnt6 got=%0d exp=%0d", match_count, CNT_ON);
        end
      end
    end
    drive(1'b0, 1'b0, d);
    total++;
    if (match_count !== 2'(2 * CNT_ON)) begin
      bad++;
      $display("FAIL novl_cnt8 got=%0d exp=%0d", match_count, 2 * CNT_ON);
    end
  endtask

  task automatic test_gaps();
    logic d;
    logic [7:0] v;
    logic [7:0] s;
    logic [7:0] e;
    v = 8'b11100010;
    s = 8'b10101000;
    e = 8'b00000010;
    do_reset();
    load(8'h0A, 4'd4, 1'b1, 1'b0, 1'b0);
    for (int i = 7; i >= 0; i--) begin
      drive(v[i], s[i], d);
      total++;
      if (d !== e[i]) begin
        bad++;
        $display("FAIL gap_step%0d got=%0b exp=%0b", 8 - i, d, e[i]);
      end
    end
  endtask

  task automatic test_clamp();
    logic d;
    logic [7:0] s;
    s = 8'hA5;
    do_reset();
    load(8'hA5, 4'd15, 1'b1, 1'b0, 1'b0);
    total++;
    if (armed !== 1'b1) begin
      bad++;
      $display("FAIL clamp_armed got=%0b exp=1", armed);
    end
    for (int i = 7; i >= 0; i--) begin
      drive(1'b1, s[i], d);
      total++;
      if (d !== (i == 0)) begin
        bad++;
        $display("FAIL clamp_bit%0d got=%0b exp=%0b", 8 - i, d, i == 0);
      end
    end
    load(8'h00, 4'd0, 1'b1, 1'b0, 1'b0);
    total++;
    if (armed !== 1'b0) begin
      bad++;
      $display("FAIL disarm_armed got=%0b exp=0", armed);
    end
    s = 8'b00001111;
    for (int i = 7; i >= 0; i--) begin
      drive(1'b1, s[i], d);
      total++;
      if (d !== 1'b0) begin
        bad++;
        $display("FAIL disarm_bit%0d got=%0b exp=0", 8 - i, d);
      end
    end
  endtask

  task automatic test_saturation();
    logic d;
    int ec;
    do_reset();
    load(8'h01, 4'd1, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= 5; i++) begin
      drive(1'b1, 1'b1, d);
      total++;
      if (d !== 1'b1) begin
        bad++;
        $display("FAIL sat_pulse%0d got=%0b exp=1", i, d);
      end
      ec = CNT_ON * ((i > 3) ? 3 : i);
      total++;
      if (match_count !== 2'(ec)) begin
        bad++;
        $display("FAIL sat_cnt%0d got=%0d exp=%0d", i, match_count, ec);
      end
    end
  endtask

  task automatic test_priority();
    logic d;
    do_reset();
    load(8'h03, 4'd2, 1'b1, 1'b1, 1'b1);
    drive(1'b1, 1'b1, d);
    total++;
    if (d !== 1'b0) begin
      bad++;
      $display("FAIL prio_first got=%0b exp=0", d);
    end
    drive(1'b1, 1'b1, d);
    total++;
    if (d !== 1'b1) begin
      bad++;
      $display("FAIL prio_second got=%0b exp=1", d);
    end
  endtask

  task automatic test_reset_mid();
    logic d;
    logic [3:0] s;
    s = 4'b1010;
    do_reset();
    load(8'h0A, 4'd4, 1'b1, 1'b0, 1'b0);
    for (int i = 3; i >= 0; i--) drive(1'b1, s[i], d);
    total++;
    if (d !== 1'b1) begin
      bad++;
      $display("FAIL mid_pre got=%0b exp=1", d);
    end
    reset = 1'b1;
    #1;
    total++;
    if (detector_out !== 1'b0 || armed !== 1'b0) begin
      bad++;
      $display("FAIL mid_async got=%0b%0b exp=00", detector_out, armed);
    end
    @(negedge clock);
    reset = 1'b0;
    load(8'h0A, 4'd4, 1'b1, 1'b0, 1'b0);
    for (int i = 3; i >= 1; i--) drive(1'b1, s[i], d);
    reset = 1'b1;
    #1;
    total++;
    if (armed !== 1'b0) begin
      bad++;
      $display("FAIL mid_armed got=%0b exp=0", armed);
    end
    @(negedge clock);
    reset = 1'b0;
    drive(1'b1, 1'b0, d);
    total++;
    if (d !== 1'b0) begin
      bad++;
      $display("FAIL mid_bit4 got=%0b exp=0", d);
    end
  endtask

  initial begin
    reset = 1'b1;
    #12;
    reset = 1'b0;
    test_reset();
    test_overlap();
    test_nonoverlap();
    test_gaps();
    test_clamp();
    test_saturation();
    test_priority();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seq_detector_prog.md
Name: seq_detector_prog

Overview:
- Runtime-programmable serial bit-pattern detector.
- Pattern up to MAX_LEN bits, with selectable overlapping or non-overlapping match mode and a saturating match counter.
- Sits on a serial input stream. Raises a registered one-cycle pulse when the most recent valid bits equal the loaded pattern.
- Generalises the fixed "1010" Moore detector: programmable pattern and length, input qualifier, overlap control.

Parameters:
- MAX_LEN, 8, maximum pattern length in bits (2..32).
- LEN_W, 4, width of cfg_len; must hold the value MAX_LEN.
- CNT_W, 8, width of match_count.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- cfg_load  in  1  one-cycle strobe; latches cfg_pattern, cfg_len and cfg_overlap.
- cfg_pattern  in  MAX_LEN  pattern; bit [len-1] is the first bit received, bit [0] is the last.
- cfg_len  in  LEN_W  pattern length.
- cfg_overlap  in  1  1 = overlapping matches allowed, 0 = non-overlapping.
- in_valid  in  1  qualifies sequence_in for this cycle.
- sequence_in  in  1  serial data bit.
- detector_out  out  1  registered match pulse.
- match_count  out  CNT_W  saturating count of matches.
- armed  out  1  high while a valid config (len >= 1) is loaded.

Behaviour:
- Reset (async, active-high), all outputs and state cleared:
  - detector_out=0, match_count=0, armed=0.
  - Shadow pattern=0, len=0, overlap=0.
  - History shift register=0, fill counter=0.
- Config load, on a clock edge with cfg_load=1:
  - pat_q<=cfg_pattern, ovl_q<=cfg_overlap.
  - len_q<=cfg_len, clamped to MAX_LEN if cfg_len>MAX_LEN.
  - History and fill counter cleared. match_count is not cleared.
  - armed<=(clamped len != 0).
- cfg_load has priority over in_valid in the same cycle; that data bit is discarded.
- len_q=0 means disarmed: no matches, history is still shifted.
- Data path, on each edge with in_valid=1 and cfg_load=0:
  - hist<={hist[MAX_LEN-2:0], sequence_in}.
  - fill<=min(fill+1, MAX_LEN).
- Match condition, evaluated combinationally on the next-state values of hist and fill:
  - armed, and
  - fill_next >= len_q, and
  - hist_next[len_q-1:0] == pat_q[len_q-1:0].
- detector_out:
  - Registered. Goes high on the same clock edge that shifts in the final pattern bit, so it is visible one cycle after that bit's input cycle.
  - High for exactly one cycle.
  - Low on any cycle with in_valid=0.
- Overlap mode (ovl_q=1): fill is not altered on a match, so the suffix of a match may begin the next match.
- Non-overlap mode (ovl_q=0): on a match, fill<=0, so a full new len_q bits are required before the next match.
- match_count: +1 per detector_out pulse; saturates at 2^CNT_W-1 and never wraps.
- in_valid=0: hist, fill and detector_out hold (detector_out low); no state change.
- len_q=1: every valid bit equal to pat_q[0] matches. In non-overlap mode fill returns to 0 and refills each bit, giving back-to-back matches.
- Reset mid-stream: immediate clear; detector is disarmed until the next cfg_load.
- All mask/compare widths are MAX_LEN; bits above len_q are ignored.

Optional Feature:
- Macro: SEQ_DET_COUNT_EN.
- Defined: match_count is implemented as described.
- Undefined:
  - No counter flops; match_count is tied to 0.
  - detector_out and armed are unchanged.

Test Plan:
- Pattern 1010, overlapping: reset; cfg_load pattern=4'b1010 (MAX_LEN=8, pattern=8'h0A), len=4, overlap=1; stream 1,0,1,0,1,0 with in_valid=1 -> detector_out pulses after bit 4 and after bit 6; match_count=2.
- Pattern 1010, non-overlapping: same stream with overlap=0 -> single pulse after bit 4; match_count=1. Appending 1,0 -> second pulse after bit 8.
- Input gaps: stream 1,0,1 with valid, then 3 cycles in_valid=0 with sequence_in toggling, then 0 valid -> exactly one pulse, one cycle after the final valid 0; no pulse during the gap.
- Length clamp and disarm:
  - cfg_len=15 with MAX_LEN=8 -> len_q=8, armed=1; pattern 8'hA5 fed MSB-first -> 1 pulse.
  - cfg_len=0 -> armed=0; no pulses for any stream.
- Saturation and priority:
  - CNT_W=2, len=1, pattern bit 1, overlap=0, 5 consecutive valid 1s -> 5 pulses; match_count stops at 3.
  - cfg_load asserted together with a valid bit -> that bit is ignored (fill=0 next cycle).
- Async reset mid-match: assert reset between bits 3 and 4 of 1010 -> detector_out=0 and armed=0 immediately; bit 4 produces no pulse.
